// File: rtl/sram_sample_streamer_if.sv
// sram_sample_streamer_if: asynchronous SRAM read port.
// Master drives address and active-low controls; slave returns data.
interface sram_sample_streamer_if;
    logic [15:0] SRAM_DQ;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    modport master (
        input  SRAM_DQ,
        output SRAM_ADDR,
        output SRAM_CE_N,
        output SRAM_OE_N,
        output SRAM_WE_N,
        output SRAM_UB_N,
        output SRAM_LB_N
    );

    modport slave (
        output SRAM_DQ,
        input  SRAM_ADDR,
        input  SRAM_CE_N,
        input  SRAM_OE_N,
        input  SRAM_WE_N,
        input  SRAM_UB_N,
        input  SRAM_LB_N
    );
endinterface

// File: rtl/sram_sample_streamer.sv
// sram_sample_streamer: fetches 16-bit PCM words from SRAM into a FIFO, pops one per tick.
// Optional macro STREAMER_LOOP_EN: wrap to address 0 after END_ADDR instead of draining.
module sram_sample_streamer #(
    parameter int          DIV        = 1042,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [19:0] END_ADDR   = 20'hFFFFF
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    sram_sample_streamer_if.master sram,
    output logic [15:0]            sample_out,
    output logic                   sample_valid,
    output logic                   playing,
    output logic                   underrun
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CW-1:0]    TICK_LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_W,
        FETCH_L,
        DRAIN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [19:0]      r_addr;
    logic [CW-1:0]    r_cnt;
    logic [15:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_sample;
    logic             r_valid;
    logic             r_underrun;

    logic w_bus;
    logic w_full;
    logic w_empty;
    logic w_tick;
    logic w_start;
    logic w_push;
    logic w_pop;
    logic w_starve;
    logic w_last;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_tick   = (r_state != IDLE) && (r_cnt == TICK_LAST);
    assign w_start  = start && !stop && (r_state == IDLE);
    assign w_push   = !stop && (r_state == FETCH_L);
    assign w_pop    = !stop && w_tick && !w_empty;
    // An empty FIFO in DRAIN is the normal end of the clip, not a starve
    assign w_starve = !stop && w_tick && w_empty && (r_state != DRAIN);
    assign w_last   = (r_addr == END_ADDR);

    always_ff @(posedge Clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_bus  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start) w_next = FETCH_A;
            end
            FETCH_A: begin
                w_bus = !w_full;
                if (!w_full) w_next = FETCH_W;
            end
            FETCH_W: begin
                w_bus  = 1'b1;
                w_next = FETCH_L;
            end
            FETCH_L: begin
                w_bus = 1'b1;
`ifdef STREAMER_LOOP_EN
                w_next = FETCH_A;
`else
                w_next = w_last ? DRAIN : FETCH_A;
`endif
            end
            DRAIN: begin
                if (w_tick && w_empty) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (stop) w_next = IDLE;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_addr <= '0;
        end else if (w_start) begin
            r_addr <= '0;
        end else if (w_push) begin
`ifdef STREAMER_LOOP_EN
            r_addr <= w_last ? '0 : r_addr + 20'd1;
`else
            r_addr <= w_last ? r_addr : r_addr + 20'd1;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (reset || stop || r_state == IDLE) r_cnt <= '0;
        else if (w_tick)                      r_cnt <= '0;
        else                                  r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!reset && w_push) r_mem[r_wr] <= sram.SRAM_DQ;
    end

    always_ff @(posedge Clk) begin
        if (reset || stop || w_start) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_pop) r_sample <= r_mem[r_rd];
            if (w_start)       r_underrun <= 1'b0;
            else if (w_starve) r_underrun <= 1'b1;
        end
    end

    assign sram.SRAM_ADDR = r_addr;
    assign sram.SRAM_CE_N = !w_bus;
    assign sram.SRAM_OE_N = !w_bus;
    assign sram.SRAM_WE_N = 1'b1;
    assign sram.SRAM_UB_N = 1'b0;
    assign sram.SRAM_LB_N = 1'b0;

    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign playing      = (r_state != IDLE);
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_sram_sample_streamer.sv
// tb_sram_sample_streamer: directed bench with a sample scoreboard per instance.
// u1 runs DIV=16 playback; u2 runs DIV=2 to starve the FIFO.
module tb_sram_sample_streamer;

    logic Clk = 1'b0;
    logic reset;
    logic start1, stop1, start2, stop2;
    logic [15:0] so1, so2;
    logic sv1, sv2, pl1, pl2, ur1, ur2;

    always #10 Clk = ~Clk;

    sram_sample_streamer_if sif1 ();
    sram_sample_streamer_if sif2 ();

    // SRAM model: each word holds A000 + its address
    assign sif1.SRAM_DQ = 16'(20'hA000 + sif1.SRAM_ADDR);
    assign sif2.SRAM_DQ = 16'(20'hA000 + sif2.SRAM_ADDR);

    sram_sample_streamer #(
        .DIV(16), .FIFO_DEPTH(4), .END_ADDR(20'd7)
    ) u1 (
        .Clk(Clk), .reset(reset), .start(start1), .stop(stop1),
        .sram(sif1), .sample_out(so1), .sample_valid(sv1),
        .playing(pl1), .underrun(ur1)
    );

    sram_sample_streamer #(
        .DIV(2), .FIFO_DEPTH(4), .END_ADDR(20'd7)
    ) u2 (
        .Clk(Clk), .reset(reset), .start(start2), .stop(stop2),
        .sram(sif2), .sample_out(so2), .sample_valid(sv2),
        .playing(pl2), .underrun(ur2)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0     = 0;
    int np1    = 0;
    int np2    = 0;
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];
    logic [15:0] last1 = 16'h0000;
    logic [15:0] exp_v;
    logic [19:0] prev_addr1 = '0;
    logic wrapped1 = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance to the falling edge inside cycle k (cycle 1 follows start)
    task automatic goto(input int k);
        while (cyc - t0 + 1 < k) begin
            @(posedge Clk);
            #1;
        end
        @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        if (!reset && sv1) begin
            np1++;
            if (q1.size() == 0) begin
                chk("u1_spurious_pulse", q1.size(), 1);
            end else begin
                exp_v = q1.pop_front();
                last1 = exp_v;
                chk("u1_sample", so1, exp_v);
                if (np1 == 1) chk("u1_first_pulse_cycle", cyc - t0 + 1, 17);
            end
        end
        if (!reset && pl1 && prev_addr1 == 20'd7 && sif1.SRAM_ADDR == 20'd0)
            wrapped1 = 1'b1;
        prev_addr1 = sif1.SRAM_ADDR;
    end

    always @(negedge Clk) begin
        if (!reset && sv2) begin
            np2++;
            if (q2.size() == 0) begin
                chk("u2_spurious_pulse", q2.size(), 1);
            end else begin
                exp_v = q2.pop_front();
                chk("u2_sample", so2, exp_v);
            end
        end
    end

    task automatic run_start1();
        start1 = 1'b1;
        @(posedge Clk);
        #1;
        t0     = cyc;
        np1    = 0;
        start1 = 1'b0;
    endtask

    task automatic full_run(input string tag);
        for (int i = 0; i < 8; i++) q1.push_back(16'hA000 + 16'(i));
`ifdef STREAMER_LOOP_EN
        for (int i = 0; i < 4; i++) q1.push_back(16'hA000 + 16'(i));
`endif
        wrapped1 = 1'b0;
        run_start1();
        goto(1);
        chk({tag, "_c1_oe_n"}, sif1.SRAM_OE_N, 0);
        chk({tag, "_c1_ce_n"}, sif1.SRAM_CE_N, 0);
        chk({tag, "_c1_playing"}, pl1, 1);
        chk({tag, "_c1_addr"}, sif1.SRAM_ADDR, 0);
        goto(10);
        chk({tag, "_c10_ce_n"}, sif1.SRAM_CE_N, 0);
        chk({tag, "_c10_addr"}, sif1.SRAM_ADDR, 3);
        goto(13);
        chk({tag, "_c13_full_ce_n"}, sif1.SRAM_CE_N, 1);
        chk({tag, "_c13_full_oe_n"}, sif1.SRAM_OE_N, 1);
        chk({tag, "_c13_addr"}, sif1.SRAM_ADDR, 4);
        goto(40);
        start1 = 1'b1;
        @(negedge Clk);
        start1 = 1'b0;
`ifdef STREAMER_LOOP_EN
        while (np1 < 12 && cyc - t0 < 400) @(negedge Clk);
        chk({tag, "_pulses"}, np1, 12);
        chk({tag, "_addr_wrapped"}, wrapped1, 1);
        stop1 = 1'b1;
        @(negedge Clk);
        stop1 = 1'b0;
        @(negedge Clk);
        chk({tag, "_stopped"}, pl1, 0);
        chk({tag, "_underrun"}, ur1, 0);
        chk({tag, "_queue_empty"}, q1.size(), 0);
`else
        while (pl1 && cyc - t0 < 400) @(negedge Clk);
        chk({tag, "_playing_drop"}, pl1, 0);
        chk({tag, "_end_cycle"}, cyc - t0 + 1, 145);
        chk({tag, "_pulses"}, np1, 8);
        chk({tag, "_underrun"}, ur1, 0);
        chk({tag, "_addr_hold"}, sif1.SRAM_ADDR, 7);
        chk({tag, "_sample_hold"}, so1, 16'hA007);
        chk({tag, "_queue_empty"}, q1.size(), 0);
`endif
        chk({tag, "_idle_ce_n"}, sif1.SRAM_CE_N, 1);
    endtask

    initial begin
        reset  = 1'b1;
        start1 = 1'b0;
        stop1  = 1'b0;
        start2 = 1'b0;
        stop2  = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_addr", sif1.SRAM_ADDR, 0);
        chk("rst_ce_n", sif1.SRAM_CE_N, 1);
        chk("rst_oe_n", sif1.SRAM_OE_N, 1);
        chk("rst_we_n", sif1.SRAM_WE_N, 1);
        chk("rst_ub_lb", {sif1.SRAM_UB_N, sif1.SRAM_LB_N}, 0);
        chk("rst_sample", so1, 0);
        chk("rst_valid", sv1, 0);
        chk("rst_playing", pl1, 0);
        chk("rst_underrun", ur1, 0);
        chk("rst_u2_playing", pl2, 0);
        reset = 1'b0;
        repeat (2) @(negedge Clk);

        full_run("run1");

        // stop and start together while the bus is in FETCH_W
        run_start1();
        goto(2);
        chk("ss_fetch_w_ce_n", sif1.SRAM_CE_N, 0);
        stop1  = 1'b1;
        start1 = 1'b1;
        @(negedge Clk);
        stop1  = 1'b0;
        start1 = 1'b0;
        chk("ss_playing", pl1, 0);
        chk("ss_ce_n", sif1.SRAM_CE_N, 1);
        chk("ss_oe_n", sif1.SRAM_OE_N, 1);
        chk("ss_sample_kept", so1, last1);
        chk("ss_valid", sv1, 0);
        @(negedge Clk);
        chk("ss_still_idle", pl1, 0);

        // reset landing on the edge that ends FETCH_L
        run_start1();
        goto(3);
        chk("rl_fetch_l_ce_n", sif1.SRAM_CE_N, 0);
        reset = 1'b1;
        @(negedge Clk);
        chk("rl_addr", sif1.SRAM_ADDR, 0);
        chk("rl_ce_n", sif1.SRAM_CE_N, 1);
        chk("rl_oe_n", sif1.SRAM_OE_N, 1);
        chk("rl_sample", so1, 0);
        chk("rl_valid", sv1, 0);
        chk("rl_playing", pl1, 0);
        chk("rl_underrun", ur1, 0);
        reset = 1'b0;
        @(negedge Clk);

        full_run("run3");

        // DIV=2: ticks outrun the three-cycle fetch
        for (int i = 0; i < 8; i++) q2.push_back(16'hA000 + 16'(i));
        start2 = 1'b1;
        @(posedge Clk);
        #1;
        t0     = cyc;
        np2    = 0;
        start2 = 1'b0;
        goto(3);
        chk("u2_c3_underrun", ur2, 1);
        chk("u2_c3_valid", sv2, 0);
        chk("u2_c3_sample_held", so2, 0);
        goto(5);
        chk("u2_c5_valid", sv2, 1);
        goto(7);
        chk("u2_c7_valid", sv2, 0);
        chk("u2_c7_sample_held", so2, 16'hA000);
        while (np2 < 8 && cyc - t0 < 200) @(negedge Clk);
        chk("u2_pulses", np2, 8);
        stop2 = 1'b1;
        @(negedge Clk);
        stop2 = 1'b0;
        @(negedge Clk);
        chk("u2_stopped", pl2, 0);
        chk("u2_underrun_sticky", ur2, 1);
        chk("u2_queue_empty", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_sample_streamer.md
SRAM_SAMPLE_STREAMER -- requirements
Module: sram_sample_streamer

Interface
REQ-001 Parameter DIV, default 1042: sample period in Clk cycles (50 MHz / 48 kHz).
REQ-002 Parameter FIFO_DEPTH, default 4: sample buffer entries, power of two, range 2..16.
REQ-003 Parameter END_ADDR, default 20'hFFFFF: last SRAM word address of the clip.
REQ-004 Clk  in  1  system clock, 50 MHz.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  single-cycle pulse that begins playback from address 0.
REQ-007 stop  in  1  single-cycle pulse that aborts playback.
REQ-008 SRAM_DQ  in  16  SRAM read data.
REQ-009 SRAM_ADDR  out  20  SRAM word address.
REQ-010 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM controls, active-low.
REQ-011 sample_out  out  16  current signed PCM sample, held between ticks.
REQ-012 sample_valid  out  1  one-cycle pulse when sample_out updates.
REQ-013 playing  out  1  high from the cycle after start until playback ends.
REQ-014 underrun  out  1  sticky flag: a tick found the FIFO empty while playing.

Function
REQ-015 SRAM_WE_N SHALL be constant 1; SRAM_UB_N and SRAM_LB_N SHALL be constant 0.
REQ-016 The FSM SHALL have the states IDLE, FETCH_A, FETCH_W, FETCH_L and DRAIN.
REQ-017 In IDLE, SRAM_CE_N=SRAM_OE_N=1 and playing=0; start moves the FSM to FETCH_A with SRAM_ADDR=0, FIFO empty, tick counter=0.
REQ-018 A fetch SHALL be FETCH_A -> FETCH_W -> FETCH_L, one cycle each, with CE_N=OE_N=0 and SRAM_ADDR stable in all three cycles.
REQ-019 SRAM_DQ SHALL be pushed into the FIFO on the edge ending FETCH_L; SRAM_ADDR increments on that same edge.
REQ-020 After FETCH_L the FSM SHALL go to FETCH_A if the FIFO is not full after the push; otherwise it waits in FETCH_A with CE_N=OE_N=1 until a slot frees.
REQ-021 The tick counter SHALL count 0..DIV-1 while playing and wrap to 0; each wrap is a tick.
REQ-022 On a tick with FIFO non-empty, the head SHALL be popped into sample_out and sample_valid SHALL pulse in the next cycle; the first tick occurs DIV cycles after start.
REQ-023 On a tick with FIFO empty, sample_out SHALL hold, sample_valid SHALL stay 0 and underrun SHALL set.
REQ-024 A simultaneous push and pop SHALL both succeed, and the occupancy SHALL be unchanged.
REQ-025 When the fetch at END_ADDR completes, behaviour SHALL follow REQ-031/REQ-032.
REQ-026 In DRAIN there are no fetches; ticks continue; when the FIFO is empty at a tick, the FSM SHALL go to IDLE and playing SHALL drop, with no underrun.
REQ-027 stop in any state SHALL go to IDLE next cycle, flush the FIFO and keep sample_out; stop wins over a simultaneous start.
REQ-028 start while playing SHALL be ignored; underrun clears only on reset or an accepted start.

Reset
REQ-029 While reset is high: FSM=IDLE, SRAM_ADDR=0, CE_N=OE_N=1, FIFO empty, tick counter=0, sample_out=0, sample_valid=0, playing=0, underrun=0.
REQ-030 Reset asserted mid-fetch or mid-tick SHALL abort with no push, pop or partial state surviving.

Configuration
REQ-031 With macro STREAMER_LOOP_EN defined, the fetch at END_ADDR SHALL wrap SRAM_ADDR to 0 and continue fetching; DRAIN is unreachable.
REQ-032 Without STREAMER_LOOP_EN, the fetch at END_ADDR SHALL enter DRAIN; SRAM_ADDR holds END_ADDR.

Verification (DIV=16, FIFO_DEPTH=4, END_ADDR=7; SRAM model returns 16'hA000+addr)
REQ-033 Reset then start at cycle 0 -> OE_N low from cycle 1; four fetches fill the FIFO by cycle 13; first sample_valid at cycle 17 with sample_out=16'hA000.
REQ-034 Run without STREAMER_LOOP_EN -> eight pulses with values A000..A007; playing=0 after the eighth-plus-one tick; underrun=0.
REQ-035 Run with STREAMER_LOOP_EN -> the ninth pulse is 16'hA000; SRAM_ADDR wraps 7->0.
REQ-036 Use DIV=2 so ticks outrun the 3-cycle fetch -> underrun=1 and sample_out held on starved ticks.
REQ-037 Pulse stop and start in the same cycle during FETCH_W -> IDLE next cycle, CE_N=OE_N=1, and the old sample_out is retained.
REQ-038 Assert reset during FETCH_L -> no push; all outputs at reset values on the next cycle.
